// File: rtl/psum_accumulator_pkg.sv
// Shared configuration for the partial-sum accumulator.
// Default geometry and the controller state encoding.
package Config;

  localparam int SYS_COLS   = 2;
  localparam int P_BITWIDTH = 32;
  localparam int ACC_DEPTH  = 16;
  localparam int MAX_TILES  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

endpackage

// File: rtl/psum_accumulator_col_delay.sv
// Fixed-length delay line for one partial-sum column.
// DELAY of zero degenerates to a wire.
module col_delay #(
  parameter int W     = 32,
  parameter int DELAY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DELAY == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      logic [W-1:0] pipe [DELAY];

      // shift the column along the delay line
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DELAY; i++)
            pipe[i] <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < DELAY; i++)
            pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/psum_accumulator.sv
// Deskews column partial sums, accumulates K-tiles per output row,
// then drains finished rows through a valid/ready port.
module psum_accumulator #(
  parameter int sys_cols   = Config::SYS_COLS,
  parameter int P_BITWIDTH = Config::P_BITWIDTH,
  parameter int ACC_DEPTH  = Config::ACC_DEPTH,
  parameter int MAX_TILES  = Config::MAX_TILES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(ACC_DEPTH+1)-1:0]   cfg_len,
  input  logic [$clog2(MAX_TILES+1)-1:0]   cfg_tiles,
  input  logic                             in_valid,
  input  logic [sys_cols*P_BITWIDTH-1:0]   of_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [sys_cols*P_BITWIDTH-1:0]   out_data,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  import Config::*;

  localparam int LEN_W = $clog2(ACC_DEPTH+1);
  localparam int TIL_W = $clog2(MAX_TILES+1);
  localparam int AW    = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam int ROW_W = sys_cols*P_BITWIDTH;

  function automatic logic [P_BITWIDTH-1:0] sat_add(
    input logic [P_BITWIDTH-1:0] a,
    input logic [P_BITWIDTH-1:0] b
  );
    logic [P_BITWIDTH:0] s;
    s = {a[P_BITWIDTH-1], a} + {b[P_BITWIDTH-1], b};
    if (s[P_BITWIDTH] != s[P_BITWIDTH-1])
      sat_add = s[P_BITWIDTH] ?
        {1'b1, {(P_BITWIDTH-1){1'b0}}} :
        {1'b0, {(P_BITWIDTH-1){1'b1}}};
    else
      sat_add = s[P_BITWIDTH-1:0];
  endfunction

  logic [ROW_W-1:0] a_data;
  logic             a_valid;

  genvar j;
  generate
    for (j = 0; j < sys_cols; j++) begin : g_col
      col_delay #(
        .W     (P_BITWIDTH),
        .DELAY (sys_cols-1-j)
      ) u_col (
        .clk  (clk),
        .rst  (rst),
        .din  (of_data[j*P_BITWIDTH +: P_BITWIDTH]),
        .dout (a_data[j*P_BITWIDTH +: P_BITWIDTH])
      );
    end
  endgenerate

  col_delay #(
    .W     (1),
    .DELAY (sys_cols-1)
  ) u_vld (
    .clk  (clk),
    .rst  (rst),
    .din  (in_valid),
    .dout (a_valid)
  );

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] len_q;
  logic [TIL_W-1:0] tiles_q;
  logic [AW-1:0]    row_cnt;
  logic [TIL_W-1:0] tile_cnt;
  logic [AW-1:0]    rd_ptr;
  logic             err_q;
  logic             done_q;
  logic [ROW_W-1:0] acc_buf [ACC_DEPTH];
  logic [ROW_W-1:0] sum_row;

  logic cfg_ok;
  logic start_ok;
  logic row_last;
  logic tile_last;
  logic rd_last;
  logic acc_we;
  logic drain_hs;

  assign cfg_ok    = (cfg_len != '0) && (cfg_tiles != '0) &&
                     (int'(cfg_len) <= ACC_DEPTH) &&
                     (int'(cfg_tiles) <= MAX_TILES);
  assign start_ok  = start && (state == IDLE) && cfg_ok;
  assign row_last  = (LEN_W'(row_cnt) == len_q - LEN_W'(1));
  assign tile_last = (tile_cnt == tiles_q - TIL_W'(1));
  assign rd_last   = (LEN_W'(rd_ptr) == len_q - LEN_W'(1));
  assign acc_we    = (state == ACCUM) && a_valid;
  assign drain_hs  = (state == DRAIN) && out_ready;

  // next-state decode for the job controller
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_ok) state_nx = ACCUM;
      ACCUM: if (acc_we && row_last && tile_last) state_nx = DRAIN;
      DRAIN: if (drain_hs && rd_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // first tile overwrites, later tiles saturate-add; the entry
  // written last cycle is already visible, so cfg_len=1 needs no stall
  always_comb begin
    sum_row = '0;
    for (int c = 0; c < sys_cols; c++) begin
      if (tile_cnt == '0)
        sum_row[c*P_BITWIDTH +: P_BITWIDTH] =
          a_data[c*P_BITWIDTH +: P_BITWIDTH];
      else
        sum_row[c*P_BITWIDTH +: P_BITWIDTH] = sat_add(
          acc_buf[row_cnt][c*P_BITWIDTH +: P_BITWIDTH],
          a_data[c*P_BITWIDTH +: P_BITWIDTH]);
    end
  end

  // controller state, counters and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      len_q    <= '0;
      tiles_q  <= '0;
      row_cnt  <= '0;
      tile_cnt <= '0;
      rd_ptr   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= drain_hs && rd_last;
      if (start_ok) begin
        len_q    <= cfg_len;
        tiles_q  <= cfg_tiles;
        row_cnt  <= '0;
        tile_cnt <= '0;
        rd_ptr   <= '0;
      end else if (acc_we) begin
        if (row_last) begin
          row_cnt  <= '0;
          tile_cnt <= tile_cnt + TIL_W'(1);
        end else begin
          row_cnt  <= row_cnt + AW'(1);
        end
      end
      if (drain_hs)
        rd_ptr <= rd_ptr + AW'(1);
      if ((a_valid && state != ACCUM) ||
          (start && state == IDLE && !cfg_ok))
        err_q <= 1'b1;
      else if (start_ok)
        err_q <= 1'b0;
    end
  end

  // accumulator storage, contents undefined until written
  always_ff @(posedge clk) begin
    if (acc_we)
      acc_buf[row_cnt] <= sum_row;
  end

  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? acc_buf[rd_ptr] : '0;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator (2 columns, 32-bit sums)
// with a row-level accumulation model and a per-cycle compare.
module tb_psum_accumulator;

  localparam int C = 2;
  localparam int P = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    cfg_len = '0;
  logic [4:0]    cfg_tiles = '0;
  logic          in_valid = 1'b0;
  logic [C*P-1:0] of_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [C*P-1:0] out_data;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  psum_accumulator #(
    .sys_cols   (C),
    .P_BITWIDTH (P),
    .ACC_DEPTH  (16),
    .MAX_TILES  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_tiles (cfg_tiles),
    .in_valid  (in_valid),
    .of_data   (of_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [63:0] d;
    bit          last;
  } exp_t;

  exp_t        expq[$];
  logic [63:0] got[$];
  int          r0[$];
  int          r1[$];
  int          vectors = 0;
  int          errors = 0;
  bit          exp_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // expected rows: entry e sums rows e, e+len, ... with clamping
  task automatic load_model(input int len, input int tiles);
    for (int e = 0; e < len; e++) begin
      longint a0;
      longint a1;
      logic [31:0] w0;
      logic [31:0] w1;
      exp_t x;
      a0 = 0;
      a1 = 0;
      for (int t = 0; t < tiles; t++) begin
        a0 = clamp(a0 + longint'(r0[t*len+e]));
        a1 = clamp(a1 + longint'(r1[t*len+e]));
      end
      w0 = a0[31:0];
      w1 = a1[31:0];
      x.d = {w1, w0};
      x.last = (e == len-1);
      expq.push_back(x);
    end
  endtask

  // per-cycle compare of the drain port and done pulse
  always @(negedge clk) begin
    if (!rst) begin
      exp_done = 1'b0;
    end else begin
      check("done", {63'd0, done}, {63'd0, exp_done});
      exp_done = 1'b0;
      if (out_valid) begin
        if (expq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL out_valid: got row %h want none", out_data);
        end else begin
          check("out_data", out_data, expq[0].d);
          if (out_ready) begin
            exp_done = expq[0].last;
            got.push_back(out_data);
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  task automatic do_start(input int len, input int tiles);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_len = 5'(len);
    cfg_tiles = 5'(tiles);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // column 1 trails column 0 by one cycle
  task automatic feed();
    int n;
    n = r0.size();
    for (int c = 0; c <= n; c++) begin
      in_valid = (c < n);
      of_data[31:0]  = (c < n) ? 32'(r0[c]) : 32'd0;
      of_data[63:32] = (c > 0) ? 32'(r1[c-1]) : 32'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    of_data = '0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL %s: got no done want done", name);
    end
  endtask

  task automatic run_job(input int len, input int tiles,
                         input string name);
    got.delete();
    load_model(len, tiles);
    do_start(len, tiles);
    @(negedge clk);
    check({name, "_busy"}, {63'd0, busy}, 64'd1);
    check({name, "_err"}, {63'd0, err}, 64'd0);
    feed();
    wait_done(name);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    r0 = '{1, 3};
    r1 = '{2, 4};
    run_job(2, 1, "basic");
    check("basic_n", 64'(got.size()), 64'd2);
    check("basic_r0", got[0], 64'h00000002_00000001);
    check("basic_r1", got[1], 64'h00000004_00000003);

    r0 = '{5, 5, 5};
    r1 = '{-1, -1, -1};
    run_job(1, 3, "bypass");
    check("bypass_r", got[0], 64'hFFFFFFFD_0000000F);

    r0 = '{32'h7FFFFFF0, 32'h20};
    r1 = '{int'(32'h80000010), -32};
    run_job(1, 2, "sat");
    check("sat_hi", 64'(got[0][31:0]), 64'h7FFFFFFF);
    check("sat_lo", 64'(got[0][63:32]), 64'h80000000);

    r0 = '{10, 20, 30, 1, 2, 3};
    r1 = '{-10, -20, -30, 100, 200, 300};
    got.delete();
    out_ready = 1'b0;
    load_model(3, 2);
    do_start(3, 2);
    feed();
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      if (!seen) begin
        vectors++;
        errors++;
        $display("FAIL stall_valid: got 0 want 1");
      end
    end
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done("stall");
    check("stall_n", 64'(got.size()), 64'd3);
    check("stall_r2", got[2], {32'd270, 32'd33});

    do_start(0, 1);
    @(negedge clk);
    check("bad_cfg_err", {63'd0, err}, 64'd1);
    check("bad_cfg_busy", {63'd0, busy}, 64'd0);
    r0 = '{4};
    r1 = '{9};
    run_job(1, 1, "clr1");

    @(posedge clk); #1;
    in_valid = 1'b1;
    of_data = 64'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    of_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_vld_err", {63'd0, err}, 64'd1);
    r0 = '{-7};
    r1 = '{8};
    run_job(1, 1, "clr2");
    check("clr2_r", got[0], 64'h00000008_FFFFFFF9);

    do_start(2, 2);
    in_valid = 1'b1;
    of_data = 64'h00000000_00000007;
    @(posedge clk); #1;
    of_data = 64'h00000003_00000008;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    of_data = '0;
    @(negedge clk);
    check("mid_valid", {63'd0, out_valid}, 64'd0);
    check("mid_data", out_data, 64'd0);
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_done", {63'd0, done}, 64'd0);
    check("mid_err", {63'd0, err}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    r0 = '{1, 2, 3, 4};
    r1 = '{5, 6, 7, 8};
    run_job(2, 2, "fresh");
    check("fresh_r0", got[0], {32'd12, 32'd4});
    check("fresh_r1", got[1], {32'd14, 32'd6});

    repeat (3) @(posedge clk);
    check("model_left", 64'(expq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
